// File: rtl/axis_shutdown_pkg.sv
// Shared types for the multi-channel AXI-Stream shutdown gate: the per-channel
// state enum and the width helper for the stall counter.
package axis_shutdown_pkg;

   // Per-channel gate state
   typedef enum logic [1:0] {
      RUN   = 2'd0,   // pass-through
      DRAIN = 2'd1,   // pass-through, waiting for the open packet to close
      OFF   = 2'd2,   // gated, shutdown acknowledged
      SKIP  = 2'd3    // discarding the orphaned remainder of a packet
   } ch_state_t;

   // Bits needed to hold a stall count of 0..timeout_cycles (at least 1)
   function automatic int stall_cnt_width(input int timeout_cycles);
      int w;
      w = $clog2(timeout_cycles + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/axis_shutdown_ch.sv
// One channel of the shutdown gate: FSM, open-packet tracker, optional stall
// counter and the valid/ready gating. Data, keep, user and last are wired
// straight through; only tvalid/tready are gated.
// Optional feature: define AXIS_SHUTDOWN_TIMEOUT_EN to build the stall counter
// and forced shutdown; otherwise DRAIN waits indefinitely and timeout_flag is 0.
module axis_shutdown_ch
   import axis_shutdown_pkg::*;
#(
   parameter int C_AXIS_TDATA_WIDTH   = 32,
   parameter int C_AXIS_TUSER_WIDTH   = 1,
   parameter int C_TREADY_IN_SHUTDOWN = 0,
   parameter int C_TIMEOUT_CYCLES     = 1024
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            shutdown_req,
   output logic                            shutdown_ack,
   output logic                            timeout_flag,
   input  logic [C_AXIS_TDATA_WIDTH-1:0]   s_axis_tdata,
   input  logic [C_AXIS_TDATA_WIDTH/8-1:0] s_axis_tkeep,
   input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
   input  logic                            s_axis_tlast,
   input  logic                            s_axis_tvalid,
   output logic                            s_axis_tready,
   output logic [C_AXIS_TDATA_WIDTH-1:0]   m_axis_tdata,
   output logic [C_AXIS_TDATA_WIDTH/8-1:0] m_axis_tkeep,
   output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
   output logic                            m_axis_tlast,
   output logic                            m_axis_tvalid,
   input  logic                            m_axis_tready
);

   localparam logic TREADY_OFF = (C_TREADY_IN_SHUTDOWN != 0);

   ch_state_t state_reg, state_next;
   logic      in_pkt_reg, in_pkt_next;
   logic      ack_reg;
   logic      timeout_reg, timeout_next;
   logic      pass;
   logic      accept;
   logic      timeout_hit;

   assign pass   = (state_reg == RUN) || (state_reg == DRAIN);
   assign accept = s_axis_tvalid & s_axis_tready;

   // Any accepted beat, whatever the state, moves the packet boundary tracker
   assign in_pkt_next = accept ? ~s_axis_tlast : in_pkt_reg;

   assign m_axis_tdata  = s_axis_tdata;
   assign m_axis_tkeep  = s_axis_tkeep;
   assign m_axis_tuser  = s_axis_tuser;
   assign m_axis_tlast  = s_axis_tlast;
   assign m_axis_tvalid = pass & s_axis_tvalid;

   assign shutdown_ack = ack_reg;
   assign timeout_flag = timeout_reg;

   // Upstream ready: follow downstream while passing, fixed value while gated
   always_comb begin
      s_axis_tready = m_axis_tready;
      case (state_reg)
         OFF:     s_axis_tready = TREADY_OFF;
         SKIP:    s_axis_tready = 1'b1;
         default: s_axis_tready = m_axis_tready;
      endcase
   end

`ifdef AXIS_SHUTDOWN_TIMEOUT_EN
   localparam int            CW    = stall_cnt_width(C_TIMEOUT_CYCLES);
   localparam logic [CW-1:0] LIMIT = CW'(C_TIMEOUT_CYCLES);

   logic [CW-1:0] stall_cnt_reg;

   // Count consecutive DRAIN cycles without an accepted beat; saturate at LIMIT
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_reg <= '0;
      end else if ((state_reg == DRAIN) && !accept) begin
         if (stall_cnt_reg != LIMIT) begin
            stall_cnt_reg <= stall_cnt_reg + CW'(1);
         end
      end else begin
         stall_cnt_reg <= '0;
      end
   end

   // A beat arriving in the limit cycle wins over the timeout
   assign timeout_hit = (state_reg == DRAIN) && !accept && (stall_cnt_reg == LIMIT);
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = (C_TIMEOUT_CYCLES == 0);
   assign timeout_hit        = 1'b0;
`endif

   // Next-state: withdrawing the request out of DRAIN takes priority so a
   // cancelled shutdown never produces an acknowledge
   always_comb begin
      state_next   = state_reg;
      timeout_next = 1'b0;
      case (state_reg)
         RUN: begin
            if (shutdown_req) begin
               state_next = in_pkt_next ? DRAIN : OFF;
            end
         end
         DRAIN: begin
            if (!shutdown_req) begin
               state_next = RUN;
            end else if (accept && s_axis_tlast) begin
               state_next = OFF;
            end else if (timeout_hit) begin
               state_next   = OFF;
               timeout_next = 1'b1;
            end
         end
         OFF: begin
            if (!shutdown_req) begin
               state_next = in_pkt_next ? SKIP : RUN;
            end
         end
         SKIP: begin
            if (shutdown_req) begin
               state_next = OFF;
            end else if (accept && s_axis_tlast) begin
               state_next = RUN;
            end
         end
         default: state_next = RUN;
      endcase
   end

   // State, packet tracker and registered status outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= RUN;
         in_pkt_reg  <= 1'b0;
         ack_reg     <= 1'b0;
         timeout_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         in_pkt_reg  <= in_pkt_next;
         ack_reg     <= (state_next == OFF);
         timeout_reg <= timeout_next;
      end
   end

endmodule

// File: rtl/axis_shutdown_mc.sv
// Multi-channel packet-aware AXI-Stream shutdown gate. Each channel is an
// independent axis_shutdown_ch; this level only slices the flat buses.
// Optional feature: AXIS_SHUTDOWN_TIMEOUT_EN enables stall timeouts per channel.
// A reset mid-packet loses packet state; the rest of that packet is forwarded.
module axis_shutdown_mc
   import axis_shutdown_pkg::*;
#(
   parameter int C_NUM_CHANNELS       = 4,
   parameter int C_AXIS_TDATA_WIDTH   = 32,
   parameter int C_AXIS_TUSER_WIDTH   = 1,
   parameter int C_TREADY_IN_SHUTDOWN = 0,
   parameter int C_TIMEOUT_CYCLES     = 1024
) (
   input  logic                                           clk,
   input  logic                                           rst,
   input  logic [C_NUM_CHANNELS-1:0]                      shutdown_req,
   output logic [C_NUM_CHANNELS-1:0]                      shutdown_ack,
   output logic [C_NUM_CHANNELS-1:0]                      timeout_flag,
   input  logic [C_NUM_CHANNELS*C_AXIS_TDATA_WIDTH-1:0]   s_axis_tdata,
   input  logic [C_NUM_CHANNELS*C_AXIS_TDATA_WIDTH/8-1:0] s_axis_tkeep,
   input  logic [C_NUM_CHANNELS*C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
   input  logic [C_NUM_CHANNELS-1:0]                      s_axis_tlast,
   input  logic [C_NUM_CHANNELS-1:0]                      s_axis_tvalid,
   output logic [C_NUM_CHANNELS-1:0]                      s_axis_tready,
   output logic [C_NUM_CHANNELS*C_AXIS_TDATA_WIDTH-1:0]   m_axis_tdata,
   output logic [C_NUM_CHANNELS*C_AXIS_TDATA_WIDTH/8-1:0] m_axis_tkeep,
   output logic [C_NUM_CHANNELS*C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
   output logic [C_NUM_CHANNELS-1:0]                      m_axis_tlast,
   output logic [C_NUM_CHANNELS-1:0]                      m_axis_tvalid,
   input  logic [C_NUM_CHANNELS-1:0]                      m_axis_tready
);

   localparam int W  = C_AXIS_TDATA_WIDTH;
   localparam int KW = C_AXIS_TDATA_WIDTH / 8;
   localparam int U  = C_AXIS_TUSER_WIDTH;

   // One independent gate per channel, channel gi on slice gi of every bus
   generate
      for (genvar gi = 0; gi < C_NUM_CHANNELS; gi++) begin : g_ch
         axis_shutdown_ch #(
            .C_AXIS_TDATA_WIDTH   (W),
            .C_AXIS_TUSER_WIDTH   (U),
            .C_TREADY_IN_SHUTDOWN (C_TREADY_IN_SHUTDOWN),
            .C_TIMEOUT_CYCLES     (C_TIMEOUT_CYCLES)
         ) u_ch (
            .clk           (clk),
            .rst           (rst),
            .shutdown_req  (shutdown_req[gi]),
            .shutdown_ack  (shutdown_ack[gi]),
            .timeout_flag  (timeout_flag[gi]),
            .s_axis_tdata  (s_axis_tdata[gi*W +: W]),
            .s_axis_tkeep  (s_axis_tkeep[gi*KW +: KW]),
            .s_axis_tuser  (s_axis_tuser[gi*U +: U]),
            .s_axis_tlast  (s_axis_tlast[gi]),
            .s_axis_tvalid (s_axis_tvalid[gi]),
            .s_axis_tready (s_axis_tready[gi]),
            .m_axis_tdata  (m_axis_tdata[gi*W +: W]),
            .m_axis_tkeep  (m_axis_tkeep[gi*KW +: KW]),
            .m_axis_tuser  (m_axis_tuser[gi*U +: U]),
            .m_axis_tlast  (m_axis_tlast[gi]),
            .m_axis_tvalid (m_axis_tvalid[gi]),
            .m_axis_tready (m_axis_tready[gi])
         );
      end
   endgenerate

endmodule

// File: tb/tb_axis_shutdown_mc.sv
// Bench for axis_shutdown_mc: two instances share one stimulus, instance 0
// blocks upstream while gated, instance 1 sinks and discards. Per-channel
// behavioural model of the gate rules checked every cycle, plus directed
// scenario checks on counted beats and acknowledges.
module tb_axis_shutdown_mc;

   localparam int N  = 4;
   localparam int W  = 32;
   localparam int KW = W / 8;
   localparam int U  = 1;
   localparam int TO = 16;
`ifdef AXIS_SHUTDOWN_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif
   localparam int M_RUN = 0, M_DRAIN = 1, M_OFF = 2, M_SKIP = 3;

   logic clk = 1'b0;
   logic rst;
   logic [N-1:0]    req;
   logic [N*W-1:0]  s_tdata;
   logic [N*KW-1:0] s_tkeep;
   logic [N*U-1:0]  s_tuser;
   logic [N-1:0]    s_tlast, s_tvalid, m_tready;

   logic [N-1:0]    ack [2];
   logic [N-1:0]    tf [2];
   logic [N-1:0]    s_tready [2];
   logic [N*W-1:0]  m_tdata [2];
   logic [N*KW-1:0] m_tkeep [2];
   logic [N*U-1:0]  m_tuser [2];
   logic [N-1:0]    m_tlast [2];
   logic [N-1:0]    m_tvalid [2];

   always #5 clk = ~clk;

   axis_shutdown_mc #(
      .C_NUM_CHANNELS(N), .C_AXIS_TDATA_WIDTH(W), .C_AXIS_TUSER_WIDTH(U),
      .C_TREADY_IN_SHUTDOWN(0), .C_TIMEOUT_CYCLES(TO)
   ) dut_block (
      .clk(clk), .rst(rst), .shutdown_req(req), .shutdown_ack(ack[0]), .timeout_flag(tf[0]),
      .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tuser(s_tuser),
      .s_axis_tlast(s_tlast), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready[0]),
      .m_axis_tdata(m_tdata[0]), .m_axis_tkeep(m_tkeep[0]), .m_axis_tuser(m_tuser[0]),
      .m_axis_tlast(m_tlast[0]), .m_axis_tvalid(m_tvalid[0]), .m_axis_tready(m_tready)
   );

   axis_shutdown_mc #(
      .C_NUM_CHANNELS(N), .C_AXIS_TDATA_WIDTH(W), .C_AXIS_TUSER_WIDTH(U),
      .C_TREADY_IN_SHUTDOWN(1), .C_TIMEOUT_CYCLES(TO)
   ) dut_sink (
      .clk(clk), .rst(rst), .shutdown_req(req), .shutdown_ack(ack[1]), .timeout_flag(tf[1]),
      .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tuser(s_tuser),
      .s_axis_tlast(s_tlast), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready[1]),
      .m_axis_tdata(m_tdata[1]), .m_axis_tkeep(m_tkeep[1]), .m_axis_tuser(m_tuser[1]),
      .m_axis_tlast(m_tlast[1]), .m_axis_tvalid(m_tvalid[1]), .m_axis_tready(m_tready)
   );

   // Reference model state per instance and channel
   int md [2][N];
   bit pk [2][N];
   int st [2][N];
   bit eack [2][N];
   bit etf [2][N];
   int md_n [2][N];
   bit pk_n [2][N];
   int st_n [2][N];
   bit tf_n [2][N];
   bit acc_n [2][N];

   // Observation counters for directed scenarios
   int fwd [2][N];
   int sunk [2][N];
   int acks [2][N];
   int tfs [2][N];

   // Packet generator per channel (advances on instance 1 acceptance)
   logic [W-1:0]  bdat [N];
   logic [KW-1:0] bkeep [N];
   logic [U-1:0]  buser [N];
   int gbeat [N];
   int glen [N];
   int flen [N];
   int vprob [N];
   int rprob [N];

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string tag, input int i, input int c,
                      input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s inst=%0d ch=%0d cyc=%0d observed=%0h expected=%0h",
                tag, i, c, cyc, got, exp);
      end
   endtask

   task automatic new_beat(input int c);
      bdat[c]  = $urandom;
      bkeep[c] = KW'($urandom);
      buser[c] = U'($urandom);
   endtask

   task automatic new_pkt(input int c);
      gbeat[c] = 0;
      glen[c]  = (flen[c] > 0) ? flen[c] : int'($urandom_range(6, 1));
   endtask

   task automatic force_pkt(input int c, input int len);
      flen[c] = len;
      glen[c] = len;
   endtask

   task automatic clear_counts();
      for (int i = 0; i < 2; i++) begin
         for (int c = 0; c < N; c++) begin
            fwd[i][c] = 0; sunk[i][c] = 0; acks[i][c] = 0; tfs[i][c] = 0;
         end
      end
   endtask

   task automatic drive();
      for (int c = 0; c < N; c++) begin
         s_tvalid[c]           = (int'($urandom_range(99, 0)) < vprob[c]);
         m_tready[c]           = (int'($urandom_range(99, 0)) < rprob[c]);
         s_tdata[c*W +: W]     = bdat[c];
         s_tkeep[c*KW +: KW]   = bkeep[c];
         s_tuser[c*U +: U]     = buser[c];
         s_tlast[c]            = (gbeat[c] == glen[c] - 1);
      end
   endtask

   // Compare DUT against the model and work out the model's next step
   task automatic evaluate();
      for (int i = 0; i < 2; i++) begin
         for (int c = 0; c < N; c++) begin
            bit sv, sl, mr, rq, pass, ev, er, acc, pkn, fired;
            int n;
            sv = s_tvalid[c]; sl = s_tlast[c]; mr = m_tready[c]; rq = req[c];
            pass = (md[i][c] == M_RUN) || (md[i][c] == M_DRAIN);
            ev   = pass && sv;
            er   = pass ? mr : ((md[i][c] == M_OFF) ? (i == 1) : 1'b1);
            if (chk_en) begin
               chk("m_tvalid", i, c, m_tvalid[i][c], ev);
               chk("s_tready", i, c, s_tready[i][c], er);
               chk("shutdown_ack", i, c, ack[i][c], eack[i][c]);
               chk("timeout_flag", i, c, tf[i][c], etf[i][c]);
               chk("payload", i, c,
                   {m_tdata[i][c*W +: W], m_tkeep[i][c*KW +: KW], m_tuser[i][c*U +: U], m_tlast[i][c]},
                   {bdat[c], bkeep[c], buser[c], sl});
            end
            fwd[i][c]  += (m_tvalid[i][c] && mr) ? 1 : 0;
            sunk[i][c] += (sv && s_tready[i][c]) ? 1 : 0;
            acks[i][c] += ack[i][c] ? 1 : 0;
            tfs[i][c]  += tf[i][c] ? 1 : 0;
            acc   = sv && er;
            pkn   = acc ? !sl : pk[i][c];
            n     = md[i][c];
            fired = 1'b0;
            if (md[i][c] == M_RUN) begin
               if (rq) n = pkn ? M_DRAIN : M_OFF;
            end else if (md[i][c] == M_DRAIN) begin
               if (!rq) n = M_RUN;
               else if (acc && sl) n = M_OFF;
               else if (TO_EN && !acc && st[i][c] == TO) begin n = M_OFF; fired = 1'b1; end
            end else if (md[i][c] == M_OFF) begin
               if (!rq) n = pkn ? M_SKIP : M_RUN;
            end else begin
               if (rq) n = M_OFF;
               else if (acc && sl) n = M_RUN;
            end
            md_n[i][c]  = n;
            pk_n[i][c]  = pkn;
            st_n[i][c]  = (md[i][c] == M_DRAIN && !acc) ? ((st[i][c] < TO) ? st[i][c] + 1 : TO) : 0;
            tf_n[i][c]  = fired;
            acc_n[i][c] = acc;
         end
      end
   endtask

   task automatic commit();
      for (int i = 0; i < 2; i++) begin
         for (int c = 0; c < N; c++) begin
            if (rst) begin
               md[i][c] = M_RUN; pk[i][c] = 1'b0; st[i][c] = 0; eack[i][c] = 1'b0; etf[i][c] = 1'b0;
            end else begin
               md[i][c]   = md_n[i][c];
               pk[i][c]   = pk_n[i][c];
               st[i][c]   = st_n[i][c];
               eack[i][c] = (md_n[i][c] == M_OFF);
               etf[i][c]  = tf_n[i][c];
            end
         end
      end
      for (int c = 0; c < N; c++) begin
         if (acc_n[1][c]) begin
            if (s_tlast[c]) new_pkt(c);
            else gbeat[c]++;
            new_beat(c);
         end
      end
   endtask

   task automatic step();
      drive();
      #4;
      evaluate();
      @(posedge clk);
      commit();
      cyc++;
      #1;
   endtask

   // Run channel c flat out until it sits on a packet boundary in RUN
   task automatic wait_idle(input int c);
      bit ok;
      req[c] = 1'b0; vprob[c] = 100; rprob[c] = 100;
      ok = 1'b0;
      for (int k = 0; k < 200 && !ok; k++) begin
         step();
         ok = (gbeat[c] == 0) && (md[0][c] == M_RUN) && (md[1][c] == M_RUN) && !pk[0][c] && !pk[1][c];
      end
      chk("idle_reached", 0, c, ok, 1);
   endtask

   initial begin
      rst = 1'b1;
      req = '0;
      for (int c = 0; c < N; c++) begin
         flen[c] = 0; vprob[c] = 70; rprob[c] = 70;
         new_pkt(c); new_beat(c);
         for (int i = 0; i < 2; i++) begin
            md[i][c] = M_RUN; pk[i][c] = 1'b0; st[i][c] = 0; eack[i][c] = 1'b0; etf[i][c] = 1'b0;
            acc_n[i][c] = 1'b0;
         end
      end
      clear_counts();
      @(posedge clk);
      #1;
      step();
      chk_en = 1'b1;
      step();
      rst = 1'b0;
      repeat (40) step();

      // Idle shutdown on ch0 while others stream
      wait_idle(0);
      vprob[0] = 0; req[0] = 1'b1;
      step();
      for (int i = 0; i < 2; i++) chk("idle_ack", i, 0, ack[i][0], 1);
      force_pkt(0, 4); vprob[0] = 100; clear_counts();
      repeat (8) step();
      for (int i = 0; i < 2; i++) chk("off_fwd", i, 0, fwd[i][0], 0);
      chk("off_sunk", 0, 0, sunk[0][0], 0);
      chk("off_sunk", 1, 0, sunk[1][0], 8);
      vprob[0] = 0; req[0] = 1'b0;
      step();
      for (int i = 0; i < 2; i++) chk("ack_fall", i, 0, ack[i][0], 0);
      chk("sink_resume_run", 1, 0, md[1][0], M_RUN);
      flen[0] = 0; vprob[0] = 70; rprob[0] = 70;

      // Mid-packet request on ch1: 8-beat packet, request while beat 4 is accepted
      wait_idle(1);
      force_pkt(1, 8); clear_counts();
      repeat (3) step();
      req[1] = 1'b1;
      repeat (8) step();
      for (int i = 0; i < 2; i++) begin
         chk("drain_fwd", i, 1, fwd[i][1], 8);
         chk("drain_ack_cycles", i, 1, acks[i][1], 3);
      end
      flen[1] = 0; req[1] = 1'b0;
      repeat (12) step();
      vprob[1] = 70; rprob[1] = 70;

      // Aborted drain on ch2: request rises and falls mid-packet
      wait_idle(2);
      force_pkt(2, 8); clear_counts();
      repeat (2) step();
      req[2] = 1'b1;
      repeat (2) step();
      req[2] = 1'b0;
      for (int k = 0; k < 40 && gbeat[2] != 0; k++) step();
      for (int i = 0; i < 2; i++) begin
         chk("abort_fwd", i, 2, fwd[i][2], 8);
         chk("abort_acks", i, 2, acks[i][2], 0);
      end
      flen[2] = 0; vprob[2] = 70; rprob[2] = 70;

      // Stall in DRAIN on ch3: upstream goes quiet after beat 3
      wait_idle(3);
      force_pkt(3, 8); clear_counts();
      repeat (3) step();
      vprob[3] = 0; req[3] = 1'b1;
      repeat (TO + 4) step();
      for (int i = 0; i < 2; i++) begin
         chk("tmo_pulses", i, 3, tfs[i][3], TO_EN ? 1 : 0);
         chk("tmo_ack", i, 3, ack[i][3], TO_EN ? 1 : 0);
      end
      req[3] = 1'b0; vprob[3] = 100; clear_counts();
      for (int k = 0; k < 40 && gbeat[3] != 0; k++) step();
      for (int i = 0; i < 2; i++) chk("tail_fwd", i, 3, fwd[i][3], TO_EN ? 0 : 5);
      force_pkt(3, 3); clear_counts();
      repeat (3) step();
      for (int i = 0; i < 2; i++) chk("next_pkt_fwd", i, 3, fwd[i][3], 3);
      flen[3] = 0; vprob[3] = 70; rprob[3] = 70;

      // Reset while ch0 drains
      wait_idle(0);
      force_pkt(0, 8);
      repeat (2) step();
      req[0] = 1'b1;
      step();
      chk("pre_rst_drain", 0, 0, md[0][0], M_DRAIN);
      rst = 1'b1;
      step();
      rst = 1'b0; req[0] = 1'b0;
      for (int i = 0; i < 2; i++) chk("rst_ack", i, 0, ack[i][0], 0);
      repeat (4) step();
      flen[0] = 0; vprob[0] = 70; rprob[0] = 70;

      // Random traffic with random requests and rare resets
      for (int k = 0; k < 400; k++) begin
         for (int c = 0; c < N; c++) begin
            if ($urandom_range(99, 0) < 4) req[c] = ~req[c];
         end
         rst = ($urandom_range(199, 0) == 0);
         step();
      end
      rst = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
